// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter and the core-side round-robin pickers.
package mem_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 1001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Width of a core id; never less than one bit so a single-core build still has a field.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, searching cyclically.
module rr_pick
    import mem_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o,
    output logic           any_o
);

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o                         = 1'b1;
                gnt_o[(int'(ptr_i) + k) % N]  = 1'b1;
                id_o                          = IDW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises core load/store requests onto a single-port memory, round-robin, one access in flight.
// Optional out-of-range rejection enabled by defining MEM_PORT_ADDR_CHECK_EN.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_done,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        core_err,
    output logic                        mem_write,
    output logic                        mem_read,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out
);

    localparam int IDW = clog2(N_CORES);

    arb_state_t          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [N_CORES-1:0]  gnt_q, gnt_d;
    logic [N_CORES-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                write_q, write_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                bad_q, bad_d;

    logic [N_CORES-1:0]  pick_gnt;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_bad;

    rr_pick #(
        .N   (N_CORES),
        .IDW (IDW)
    ) u_pick (
        .req_i (core_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

    assign win_addr  = core_addr[pick_id*ADDR_W +: ADDR_W];
    assign win_wdata = core_wdata[pick_id*DATA_W +: DATA_W];

`ifdef MEM_PORT_ADDR_CHECK_EN
    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
    assign win_bad  = (32'(win_addr) >= DEPTH_U);
    assign core_err = err_q;
`else
    assign win_bad  = 1'b0;
    assign core_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        gnt_d    = '0;
        done_d   = '0;
        rdata_d  = rdata_q;
        write_d  = 1'b0;
        read_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        bad_d    = bad_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    id_d    = pick_id;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    bad_d   = win_bad;
                    // A rejected access still takes its ACCESS slot, just with no strobe.
                    write_d = core_we[pick_id] & ~win_bad;
                    read_d  = ~core_we[pick_id] & ~win_bad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                done_d[id_q] = 1'b1;
                err_d        = bad_q;
                if (read_q) begin
                    rdata_d = mem_data_out;
                end
                rr_ptr_d = (int'(id_q) == N_CORES - 1) ? '0 : id_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
        end
    end

    assign core_gnt    = gnt_q;
    assign core_done   = done_q;
    assign core_rdata  = rdata_q;
    assign mem_write   = write_q;
    assign mem_read    = read_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1001;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      core_req, core_we;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_gnt, core_done;
    logic [DW-1:0]     core_rdata;
    logic              core_err, mem_write, mem_read;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Environment memory: combinational read, write committed at the clock edge.
    logic [DW-1:0] mem [0:DEPTH-1];
    assign mem_data_out = (int'(mem_address) < DEPTH) ? mem[int'(mem_address)] : '0;
    always @(posedge clk) begin
        if (mem_write && int'(mem_address) < DEPTH) mem[int'(mem_address)] <= mem_data_in;
    end

    // Transaction-level reference model.
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            m_busy, m_we, m_bad;
    int            m_id, m_rr, m_addr;
    logic [DW-1:0] m_data, m_rdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    int            gnt_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input bit we, input int addr, input int data);
        core_req[c]               = 1'b1;
        core_we[c]                = we;
        core_addr[c*AW +: AW]     = AW'(addr);
        core_wdata[c*DW +: DW]    = DW'(data);
    endtask

    task automatic cycle();
        logic [N-1:0] e_gnt, e_done;
        logic         e_wr, e_rd, e_err;
        e_gnt = '0; e_done = '0; e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
        if (reset) begin
            m_busy = 0; m_rr = 0; m_rdata = '0; exp_addr = '0; exp_wdata = '0;
        end else if (m_busy) begin
            e_done[m_id] = 1'b1;
            e_err        = m_bad;
            if (!m_bad) begin
                if (m_we) begin
                    if (m_addr < DEPTH) ref_mem[m_addr] = m_data;
                end else begin
                    m_rdata = (m_addr < DEPTH) ? ref_mem[m_addr] : '0;
                end
            end
            m_rr   = (m_id + 1) % N;
            m_busy = 0;
        end else if (core_req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (core_req[(m_rr + k) % N]) begin
                    m_id = (m_rr + k) % N;
                    break;
                end
            end
            m_we   = core_we[m_id];
            m_addr = int'(core_addr[m_id*AW +: AW]);
            m_data = core_wdata[m_id*DW +: DW];
`ifdef MEM_PORT_ADDR_CHECK_EN
            m_bad  = (m_addr >= DEPTH);
`else
            m_bad  = 0;
`endif
            e_gnt[m_id] = 1'b1;
            e_wr        = m_we && !m_bad;
            e_rd        = !m_we && !m_bad;
            exp_addr    = AW'(m_addr);
            exp_wdata   = m_data;
            m_busy      = 1;
        end
        @(posedge clk);
        #1;
        chk("gnt", 64'(core_gnt), 64'(e_gnt));
        chk("done", 64'(core_done), 64'(e_done));
        chk("rdata", 64'(core_rdata), 64'(m_rdata));
        chk("err", 64'(core_err), 64'(e_err));
        chk("mem_write", 64'(mem_write), 64'(e_wr));
        chk("mem_read", 64'(mem_read), 64'(e_rd));
        chk("mem_address", 64'(mem_address), 64'(exp_addr));
        chk("mem_data_in", 64'(mem_data_in), 64'(exp_wdata));
        for (int c = 0; c < N; c++) begin
            if (core_gnt[c]) begin
                core_req[c] = 1'b0;
                gnt_log.push_back(c);
            end
        end
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((core_req != '0 || m_busy) && n < max) begin
            cycle();
            n++;
        end
        chk("drain", 64'({core_req, m_busy}), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        m_busy = 0; m_we = 0; m_bad = 0; m_id = 0; m_rr = 0; m_addr = 0;
        m_data = '0; m_rdata = '0; exp_addr = '0; exp_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            mem[i]     = DW'(i + 1);
            ref_mem[i] = DW'(i + 1);
        end
        mem[100] = 16'd10; ref_mem[100] = 16'd10;

        do_reset();
        chk("reset_rdata", 64'(core_rdata), 64'(0));

        // Single load
        set_req(1, 0, 100, 0);
        run_idle(10);
        chk("single_load_rdata", 64'(core_rdata), 64'(10));

        // Store then load
        set_req(0, 1, 999, 16'h1234);
        run_idle(10);
        set_req(0, 0, 999, 0);
        run_idle(10);
        chk("store_load_rdata", 64'(core_rdata), 64'(16'h1234));

        // All four at once from reset
        do_reset();
        gnt_log.delete();
        for (int c = 0; c < N; c++) set_req(c, 0, c, 0);
        run_idle(20);
        chk("all4_count", 64'(gnt_log.size()), 64'(4));
        for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("all4_order", 64'(gnt_log[i]), 64'(i));
        chk("all4_last_rdata", 64'(core_rdata), 64'(4));

        // Round-robin wrap after core3
        gnt_log.delete();
        set_req(3, 0, 2, 0);
        set_req(0, 0, 1, 0);
        run_idle(20);
        chk("wrap_count", 64'(gnt_log.size()), 64'(2));
        if (gnt_log.size() == 2) begin
            chk("wrap_first", 64'(gnt_log[0]), 64'(0));
            chk("wrap_second", 64'(gnt_log[1]), 64'(3));
        end

        // Reset during ACCESS of a store (same data as held, so commit is immaterial)
        set_req(1, 1, 5, int'(ref_mem[5]));
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_req(2, 0, 7, 0);
        run_idle(10);
        chk("post_reset_rdata", 64'(core_rdata), 64'(ref_mem[7]));

`ifdef MEM_PORT_ADDR_CHECK_EN
        set_req(2, 0, 1001, 0);
        run_idle(10);
        chk("range_rdata_kept", 64'(core_rdata), 64'(ref_mem[7]));
`endif

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!core_req[c] && $urandom_range(0, 3) == 0) begin
                    set_req(c, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 15) == 0) ? 1001 + int'($urandom_range(0, 40))
                                                          : int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 65535)));
                end
            end
            cycle();
        end
        run_idle(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Initiator side of the shared single-port data memory: serialises load/store requests from N_CORES matrix-multiply cores onto the memory's write/read/address/data_in strobes and returns data_out to the requesting core.
- Round-robin fairness.
- One transaction in flight.
- Sits between the core array and data_memory in the top level.

Parameters:
- N_CORES, 4, number of requesting cores.
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MEM_DEPTH, 1001, valid locations 0..MEM_DEPTH-1; used only by the optional range check.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  N_CORES  per-core request; held high until core_gnt.
- core_we  in  N_CORES  per-core 1=store, 0=load; stable while core_req high.
- core_addr  in  N_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  packed store data, same packing.
- core_gnt  out  N_CORES  one-hot, one-cycle pulse; request accepted.
- core_done  out  N_CORES  one-hot, one-cycle pulse; transaction complete.
- core_rdata  out  DATA_W  load data shared by all cores; valid when core_done pulses for a load.
- core_err  out  1  pulses with core_done when the access was rejected (optional feature only).
- mem_write  out  1  to memory write.
- mem_read  out  1  to memory read.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out; combinational read of mem_address.

Behaviour:
- Reset:
  - All outputs are registered and go to 0: core_gnt, core_done, core_rdata, core_err, mem_write, mem_read, mem_address, mem_data_in.
  - State goes to IDLE.
  - Round-robin pointer rr_ptr goes to 0.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If core_req==0, stay in IDLE; all strobes stay low.
  - Otherwise, pick the winner: the first set bit of core_req, searching cyclically from rr_ptr.
  - At the edge:
    - core_gnt[winner] is set.
    - Latch the winner's addr and wdata into mem_address and mem_data_in.
    - Drive mem_write = core_we[winner] and mem_read = ~core_we[winner].
    - Store the winner id.
    - Move to ACCESS.
- ACCESS (exactly one cycle):
  - The memory strobe is high for this whole cycle. For a store, the memory commits at the edge that ends ACCESS.
  - At that edge:
    - core_gnt clears and the strobes clear.
    - core_done[id] pulses.
    - For a load, core_rdata is loaded from mem_data_out; for a store, core_rdata holds its previous value.
    - rr_ptr becomes (id+1) mod N_CORES.
    - State returns to IDLE.
- Timing:
  - Request seen in cycle T → gnt visible at T+1 → done/rdata visible at T+2.
  - Maximum throughput is one transaction per 2 cycles.
- The granted core must drop core_req in the cycle it sees core_gnt. If it keeps req high, the arbiter treats it as a new request in the next IDLE.
- mem_write and mem_read are never high at the same time. Neither is high outside ACCESS.
- A req that rises while the FSM is in ACCESS waits for the next IDLE and is not lost.
- rr_ptr wrap: N_CORES-1 wraps to 0. A lone requester is granted every other cycle regardless of rr_ptr.
- Reset during ACCESS:
  - Strobes drop at that edge.
  - No core_done is issued; the transaction is abandoned.
  - A store may or may not have committed.
- Address and data are passed through unchanged, with no width conversion.

Optional Feature:
- Macro: MEM_PORT_ADDR_CHECK_EN.
- Defined:
  - In IDLE, if the winner's addr >= MEM_DEPTH, the arbiter still issues gnt and moves to ACCESS, but keeps mem_write and mem_read low.
  - At the end of ACCESS it pulses core_done[id] and core_err together.
  - core_rdata is unchanged; rr_ptr advances as normal.
- Not defined:
  - No comparison is made.
  - core_err is tied to 0.
  - All addresses reach the memory.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - MEM_DEPTH (1001).
  - The state typedef {IDLE, ACCESS}.
  - The core-id width function clog2(N_CORES).
- Natural sub-module: rr_pick. It is purely combinational: (req, rr_ptr) → one-hot winner + id. It is reused by later core-side arbiters.

Test Plan:
- Single load:
  - Preload mem[100]=10; core1 requests load at addr 100.
  - Expected: gnt[1] at T+1 with mem_read=1 and mem_address=100; done[1] and core_rdata=10 at T+2.
- Store then load:
  - core0 stores 0x1234 at addr 999, then loads addr 999.
  - Expected: mem_write pulses once with mem_data_in=0x1234; the later load returns 0x1234.
- All four cores request loads of addr 0..3 (data 1..4) at once from reset.
  - Expected: grant order 0,1,2,3; done pulses 2 cycles apart; rdata 1,2,3,4.
- Round-robin wrap:
  - After core3 is served, core3 and core0 both request.
  - Expected: core0 is granted first (rr_ptr=0), then core3.
- Reset during ACCESS of a store to addr 5:
  - Expected: strobes 0 at the next edge; no done; rr_ptr=0; next request from core2 is served normally.
- With MEM_PORT_ADDR_CHECK_EN:
  - core2 requests a load at addr 1001.
  - Expected: gnt[2], mem_read stays 0, done[2] and core_err=1 together; core_rdata unchanged.
